// File: rtl/window_3x3_buffer_pkg.sv
// Shared definitions for the 3x3 window path: pixel and window widths, and the
// byte-lane ordering that the keypoint filter also relies on.
package window_3x3_buffer_pkg;

  localparam int PIX_W = 8;
  localparam int WIN_W = 3 * PIX_W;

  // Byte lanes inside a 24-bit row word: left = x-2, centre = x-1, right = x
  localparam int LANE_LEFT   = 0;
  localparam int LANE_CENTRE = 1;
  localparam int LANE_RIGHT  = 2;

  // Shift a new right-hand pixel into a row word; the old left pixel drops out.
  // Only the centre and right lanes of the old word survive, so they are passed in.
  function automatic logic [WIN_W-1:0] shift_in(input logic [2*PIX_W-1:0] upper,
                                                input logic [PIX_W-1:0]   pix);
    logic [WIN_W-1:0] r;
    r = '0;
    r[LANE_LEFT*PIX_W   +: PIX_W] = upper[PIX_W-1:0];
    r[LANE_CENTRE*PIX_W +: PIX_W] = upper[2*PIX_W-1:PIX_W];
    r[LANE_RIGHT*PIX_W  +: PIX_W] = pix;
    return r;
  endfunction

endpackage

// File: rtl/window_3x3_buffer_line_buffer.sv
// One image row of pixel storage. Read data is registered; when read and write
// hit the same address on the same edge, the read returns the old contents.
module line_buffer
  import window_3x3_buffer_pkg::*;
#(
  parameter int DEPTH  = 640,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data
);

  logic [PIX_W-1:0] mem [DEPTH];

  // Registered read and write; contents are never reset
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end

endmodule

// File: rtl/window_3x3_buffer.sv
// Streaming 3x3 neighbourhood generator. Buffers the two previous rows and emits
// three row words forming the window that ends at the current pixel, one cycle
// after the pixel is accepted.
module window_3x3_buffer
  import window_3x3_buffer_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int COORD_W    = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PIX_W-1:0]   pixel_in,
  input  logic               pixel_valid,
  input  logic               frame_start,
  output logic [WIN_W-1:0]   win_row_0,
  output logic [WIN_W-1:0]   win_row_1,
  output logic [WIN_W-1:0]   win_row_2,
  output logic               window_valid,
  output logic [COORD_W-1:0] center_x,
  output logic [COORD_W-1:0] center_y,
  output logic               frame_done
);

  localparam int ADDR_W = $clog2(IMG_WIDTH);
  localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMG_WIDTH - 1);
  localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(IMG_HEIGHT - 1);
  localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);
  localparam logic [COORD_W-1:0] TWO      = COORD_W'(2);

  logic [COORD_W-1:0] col, row;
  logic [COORD_W-1:0] col_eff, row_eff;
  logic               vld_p0;
  logic               win_ok_p0, last_p0;
  logic [COORD_W-1:0] cx_p0, cy_p0;
  logic [ADDR_W-1:0]  addr_p0;
  logic [PIX_W-1:0]   pix_p0;
  logic [PIX_W-1:0]   lb0_rd, lb1_rd;

  // frame_start forces the accepted pixel to (0,0) whatever the counters say
  assign col_eff = frame_start ? '0 : col;
  assign row_eff = frame_start ? '0 : row;

  // Raster position of the next pixel to arrive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (pixel_valid) begin
      if (col_eff == LAST_COL) begin
        col <= '0;
        row <= (row_eff == LAST_ROW) ? '0 : row_eff + ONE;
      end else begin
        col <= col_eff + ONE;
        row <= row_eff;
      end
    end
  end

  // LB1 holds row y-1 and is rewritten with the current pixel at once.
  // LB0 holds row y-2; it is refilled one cycle later from LB1's registered
  // read, which is the old LB1 value at that column. The next access to that
  // column is a full row later, so the deferred write is never observed early.
  line_buffer #(.DEPTH(IMG_WIDTH), .ADDR_W(ADDR_W)) u_lb0 (
    .clk     (clk),
    .rd_en   (pixel_valid),
    .rd_addr (col_eff[ADDR_W-1:0]),
    .rd_data (lb0_rd),
    .wr_en   (vld_p0),
    .wr_addr (addr_p0),
    .wr_data (lb1_rd)
  );

  line_buffer #(.DEPTH(IMG_WIDTH), .ADDR_W(ADDR_W)) u_lb1 (
    .clk     (clk),
    .rd_en   (pixel_valid),
    .rd_addr (col_eff[ADDR_W-1:0]),
    .rd_data (lb1_rd),
    .wr_en   (pixel_valid),
    .wr_addr (col_eff[ADDR_W-1:0]),
    .wr_data (pixel_in)
  );

  // ---- stage p0: accepted pixel, aligned with the registered line-buffer reads ----
  // Valid for the p0 stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= pixel_valid;
  end

  // Per-pixel data for the p0 stage; only meaningful while vld_p0 is high
  always_ff @(posedge clk) begin
    if (pixel_valid) begin
      pix_p0    <= pixel_in;
      addr_p0   <= col_eff[ADDR_W-1:0];
      win_ok_p0 <= (col_eff >= TWO) && (row_eff >= TWO);
      last_p0   <= (col_eff == LAST_COL) && (row_eff == LAST_ROW);
      cx_p0     <= col_eff - ONE;
      cy_p0     <= row_eff - ONE;
    end
  end

  // ---- stage p1: window shift registers and registered outputs ----
  // Shift in the new column, raise strobes, and latch coordinates of complete windows
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_row_0    <= '0;
      win_row_1    <= '0;
      win_row_2    <= '0;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
      center_x     <= '0;
      center_y     <= '0;
    end else begin
      window_valid <= vld_p0 && win_ok_p0;
      frame_done   <= vld_p0 && last_p0;
      if (vld_p0) begin
        win_row_0 <= shift_in(win_row_0[WIN_W-1:PIX_W], lb0_rd);
        win_row_1 <= shift_in(win_row_1[WIN_W-1:PIX_W], lb1_rd);
        win_row_2 <= shift_in(win_row_2[WIN_W-1:PIX_W], pix_p0);
      end
      if (vld_p0 && win_ok_p0) begin
        center_x <= cx_p0;
        center_y <= cy_p0;
      end
    end
  end

endmodule

// File: tb/tb_window_3x3_buffer.sv
// Directed bench for window_3x3_buffer on an 8x6 image with pixel = 16*y + x.
module tb_window_3x3_buffer;
  import window_3x3_buffer_pkg::*;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    pixel_in;
  logic          pixel_valid;
  logic          frame_start;
  logic [23:0]   win_row_0, win_row_1, win_row_2;
  logic          window_valid, frame_done;
  logic [CW-1:0] center_x, center_y;

  window_3x3_buffer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .COORD_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .pixel_in     (pixel_in),
    .pixel_valid  (pixel_valid),
    .frame_start  (frame_start),
    .win_row_0    (win_row_0),
    .win_row_1    (win_row_1),
    .win_row_2    (win_row_2),
    .window_valid (window_valid),
    .center_x     (center_x),
    .center_y     (center_y),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int x;
    int y;
    bit fs;
  } ent_t;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: the pixel accepted at the last edge, and the outputs
  // expected right after the current edge
  bit          pend_v;
  int          pend_x, pend_y;
  bit          exp_wv, exp_fd, rows_known;
  logic [23:0] exp_r0, exp_r1, exp_r2;
  int          exp_cx, exp_cy;
  int          wv_seen, fd_seen;

  function automatic logic [7:0] pix(input int x, input int y);
    return 8'(16 * y + x);
  endfunction

  function automatic logic [23:0] row_word(input int x, input int y);
    return {pix(x, y), pix(x - 1, y), pix(x - 2, y)};
  endfunction

  task automatic model_reset();
    pend_v = 0; exp_wv = 0; exp_fd = 0; rows_known = 1;
    exp_r0 = '0; exp_r1 = '0; exp_r2 = '0; exp_cx = 0; exp_cy = 0;
  endtask

  // Drive one cycle (pixel or idle) and advance the model by one edge
  task automatic step(input bit v, input int x, input int y, input bit fs);
    exp_wv = pend_v && pend_x >= 2 && pend_y >= 2;
    exp_fd = pend_v && pend_x == W - 1 && pend_y == H - 1;
    if (exp_wv) begin
      exp_r0 = row_word(pend_x, pend_y - 2);
      exp_r1 = row_word(pend_x, pend_y - 1);
      exp_r2 = row_word(pend_x, pend_y);
      exp_cx = pend_x - 1;
      exp_cy = pend_y - 1;
      rows_known = 1;
    end else if (pend_v) begin
      rows_known = 0;
    end
    pend_v = v; pend_x = x; pend_y = y;
    pixel_valid = v;
    frame_start = fs;
    pixel_in    = v ? pix(x, y) : 8'($urandom);
    @(posedge clk);
    #1;
    pixel_valid = 1'b0;
    frame_start = 1'b0;
    if (window_valid) wv_seen++;
    if (frame_done)   fd_seen++;
  endtask

  task automatic test_reset();
    rst = 1'b1; pixel_valid = 1'b0; frame_start = 1'b0; pixel_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (window_valid !== 1'b0) $display("FAIL reset_wv got %b want 0", window_valid); else n_pass++;
    n_checks++; if (frame_done !== 1'b0) $display("FAIL reset_fd got %b want 0", frame_done); else n_pass++;
    n_checks++; if (win_row_0 !== 24'h0) $display("FAIL reset_r0 got %h want 0", win_row_0); else n_pass++;
    n_checks++; if (win_row_1 !== 24'h0) $display("FAIL reset_r1 got %h want 0", win_row_1); else n_pass++;
    n_checks++; if (win_row_2 !== 24'h0) $display("FAIL reset_r2 got %h want 0", win_row_2); else n_pass++;
    n_checks++; if (center_x !== '0) $display("FAIL reset_cx got %0d want 0", center_x); else n_pass++;
    n_checks++; if (center_y !== '0) $display("FAIL reset_cy got %0d want 0", center_y); else n_pass++;
    rst = 1'b0;
    model_reset();
    step(0, 0, 0, 0);
  endtask

  task automatic test_first_window();
    for (int i = 0; i <= 2 * W + 2; i++) begin
      step(1, i % W, i / W, i == 0);
      n_checks++;
      if (window_valid !== exp_wv) $display("FAIL first_wv i=%0d got %b want %b", i, window_valid, exp_wv); else n_pass++;
    end
    step(0, 0, 0, 0);
    n_checks++; if (window_valid !== 1'b1) $display("FAIL first_wv_pulse got %b want 1", window_valid); else n_pass++;
    n_checks++; if (win_row_0 !== 24'h020100) $display("FAIL first_r0 got %h want 020100", win_row_0); else n_pass++;
    n_checks++; if (win_row_1 !== 24'h121110) $display("FAIL first_r1 got %h want 121110", win_row_1); else n_pass++;
    n_checks++; if (win_row_2 !== 24'h222120) $display("FAIL first_r2 got %h want 222120", win_row_2); else n_pass++;
    n_checks++; if (center_x !== 10'd1 || center_y !== 10'd1) $display("FAIL first_centre got (%0d,%0d) want (1,1)", center_x, center_y); else n_pass++;
    n_checks++; if (win_row_1[LANE_CENTRE*PIX_W +: PIX_W] !== 8'h11) $display("FAIL first_centre_pix got %h want 11", win_row_1[LANE_CENTRE*PIX_W +: PIX_W]); else n_pass++;
    step(0, 0, 0, 0);
    n_checks++; if (window_valid !== 1'b0) $display("FAIL first_wv_clear got %b want 0", window_valid); else n_pass++;
  endtask

  task automatic test_row_wrap();
    for (int i = 0; i <= 3 * W + 2; i++) begin
      step(1, i % W, i / W, i == 0);
      if (i == 3 * W + 1 || i == 3 * W + 2) begin
        n_checks++;
        if (window_valid !== 1'b0) $display("FAIL wrap_no_wv pixel=(%0d,3) got %b want 0", i - 3 * W - 1, window_valid); else n_pass++;
      end
    end
    step(0, 0, 0, 0);
    n_checks++; if (window_valid !== 1'b1) $display("FAIL wrap_wv got %b want 1", window_valid); else n_pass++;
    n_checks++; if (win_row_0 !== 24'h121110) $display("FAIL wrap_r0 got %h want 121110", win_row_0); else n_pass++;
    n_checks++; if (center_x !== 10'd1 || center_y !== 10'd2) $display("FAIL wrap_centre got (%0d,%0d) want (1,2)", center_x, center_y); else n_pass++;
  endtask

  task automatic test_full_frame(input bit gaps);
    ent_t        q[$];
    logic [23:0] last_r2;
    int          last_cx, last_cy;
    string       tag;
    tag = gaps ? "gaps" : "full";
    last_r2 = '0; last_cx = 0; last_cy = 0;
    for (int i = 0; i < W * H; i++) begin
      if (gaps) repeat ($urandom_range(0, 5)) q.push_back('{v: 1'b0, x: 0, y: 0, fs: 1'b0});
      q.push_back('{v: 1'b1, x: i % W, y: i / W, fs: (i == 0)});
    end
    repeat (3) q.push_back('{v: 1'b0, x: 0, y: 0, fs: 1'b0});
    wv_seen = 0; fd_seen = 0;
    foreach (q[k]) begin
      step(q[k].v, q[k].x, q[k].y, q[k].fs);
      if (window_valid) begin last_r2 = win_row_2; last_cx = int'(center_x); last_cy = int'(center_y); end
      n_checks++; if (window_valid !== exp_wv) $display("FAIL %s_wv k=%0d got %b want %b", tag, k, window_valid, exp_wv); else n_pass++;
      n_checks++; if (frame_done !== exp_fd) $display("FAIL %s_fd k=%0d got %b want %b", tag, k, frame_done, exp_fd); else n_pass++;
      if (rows_known) begin
        n_checks++;
        if ({win_row_0, win_row_1, win_row_2} !== {exp_r0, exp_r1, exp_r2})
          $display("FAIL %s_rows k=%0d got %h %h %h want %h %h %h", tag, k, win_row_0, win_row_1, win_row_2, exp_r0, exp_r1, exp_r2);
        else n_pass++;
      end
      n_checks++;
      if (center_x !== CW'(exp_cx) || center_y !== CW'(exp_cy))
        $display("FAIL %s_centre k=%0d got (%0d,%0d) want (%0d,%0d)", tag, k, center_x, center_y, exp_cx, exp_cy);
      else n_pass++;
    end
    n_checks++; if (wv_seen != 24) $display("FAIL %s_wv_count got %0d want 24", tag, wv_seen); else n_pass++;
    n_checks++; if (fd_seen != 1) $display("FAIL %s_fd_count got %0d want 1", tag, fd_seen); else n_pass++;
    n_checks++; if (last_r2 !== 24'h575655) $display("FAIL %s_last_r2 got %h want 575655", tag, last_r2); else n_pass++;
    n_checks++; if (last_cx != 6 || last_cy != 4) $display("FAIL %s_last_centre got (%0d,%0d) want (6,4)", tag, last_cx, last_cy); else n_pass++;
  endtask

  task automatic test_restart();
    ent_t        q[$];
    int          rs_idx;
    bit          got;
    logic [23:0] f0, f1, f2;
    got = 0; f0 = '0; f1 = '0; f2 = '0;
    for (int i = 0; i <= 4 * W + 2; i++) q.push_back('{v: 1'b1, x: i % W, y: i / W, fs: (i == 0)});
    rs_idx = q.size();
    for (int i = 0; i < W * H; i++) q.push_back('{v: 1'b1, x: i % W, y: i / W, fs: (i == 0)});
    repeat (2) q.push_back('{v: 1'b0, x: 0, y: 0, fs: 1'b0});
    wv_seen = 0; fd_seen = 0;
    foreach (q[k]) begin
      step(q[k].v, q[k].x, q[k].y, q[k].fs);
      if (k > rs_idx && window_valid && !got) begin got = 1; f0 = win_row_0; f1 = win_row_1; f2 = win_row_2; end
      n_checks++; if (window_valid !== exp_wv) $display("FAIL restart_wv k=%0d got %b want %b", k, window_valid, exp_wv); else n_pass++;
      n_checks++; if (frame_done !== exp_fd) $display("FAIL restart_fd k=%0d got %b want %b", k, frame_done, exp_fd); else n_pass++;
    end
    n_checks++; if (fd_seen != 1) $display("FAIL restart_fd_count got %0d want 1", fd_seen); else n_pass++;
    n_checks++; if (wv_seen != 37) $display("FAIL restart_wv_count got %0d want 37", wv_seen); else n_pass++;
    n_checks++;
    if ({f0, f1, f2} !== {24'h020100, 24'h121110, 24'h222120})
      $display("FAIL restart_first_window got %h %h %h want 020100 121110 222120", f0, f1, f2);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i <= 3 * W + 4; i++) step(1, i % W, i / W, i == 0);
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (window_valid !== 1'b0 || frame_done !== 1'b0) $display("FAIL midrst_strobes got %b%b want 00", window_valid, frame_done); else n_pass++;
    n_checks++;
    if ({win_row_0, win_row_1, win_row_2} !== 72'h0)
      $display("FAIL midrst_rows got %h %h %h want 0", win_row_0, win_row_1, win_row_2);
    else n_pass++;
    n_checks++; if (center_x !== '0 || center_y !== '0) $display("FAIL midrst_centre got (%0d,%0d) want (0,0)", center_x, center_y); else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i <= 2 * W + 2; i++) begin
      step(1, i % W, i / W, 1'b0);
      n_checks++;
      if (window_valid !== exp_wv) $display("FAIL midrst_wv i=%0d got %b want %b", i, window_valid, exp_wv); else n_pass++;
    end
    step(0, 0, 0, 0);
    n_checks++; if (window_valid !== 1'b1) $display("FAIL midrst_first_wv got %b want 1", window_valid); else n_pass++;
    n_checks++;
    if ({win_row_0, win_row_1, win_row_2} !== {24'h020100, 24'h121110, 24'h222120})
      $display("FAIL midrst_first_window got %h %h %h want 020100 121110 222120", win_row_0, win_row_1, win_row_2);
    else n_pass++;
    n_checks++; if (center_x !== 10'd1 || center_y !== 10'd1) $display("FAIL midrst_centre1 got (%0d,%0d) want (1,1)", center_x, center_y); else n_pass++;
  endtask

  initial begin
    model_reset();
    pixel_valid = 1'b0;
    frame_start = 1'b0;
    pixel_in    = 8'h00;
    test_reset();
    test_first_window();
    test_row_wrap();
    test_full_frame(1'b0);
    test_full_frame(1'b1);
    test_restart();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
